// File: rtl/moka_rv32_mem_arbiter.sv
// moka_rv32_mem_arbiter: shares one memory bus between the RV32I fetch and data ports.
// Define MEM_ARB_TIMEOUT_EN to abort an unacknowledged access after TIMEOUT cycles and raise bus_err_o.
module moka_rv32_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_valid_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  stall_if_o,
  output logic                  stall_dm_o,
  output logic                  bus_err_o
);
  localparam logic [1:0] IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2, RESP = 2'd3;
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);
  logic [1:0] state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rdata;
  logic if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic busy, done, timeout, grant_dm;
  assign busy = state_q == BUSY_IF || state_q == BUSY_DM;
  assign grant_dm = dm_req_i && (!if_req_i || starve_q < SW'(MAX_WAIT));
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic bus_err_q;
  // an ack in the timeout cycle wins, so the abort is qualified by !mem_ack_i
  assign timeout = busy && !mem_ack_i && to_q == TW'(TIMEOUT - 1);
  assign to_d = busy ? to_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      bus_err_q <= bus_err_q | timeout;
    end
  end
  assign bus_err_o = bus_err_q;
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif
  assign done  = busy && (mem_ack_i || timeout);
  assign rdata = mem_ack_i ? mem_rdata_i : ERR_DATA;
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = done && state_q == BUSY_IF;
    dm_valid_d  = done && state_q == BUSY_DM;
    if_rdata_d  = if_valid_d ? rdata : if_rdata_q;
    dm_rdata_d  = dm_valid_d ? rdata : dm_rdata_q;
    case (state_q)
      IDLE: begin
        // a data grant with fetch waiting implies starve_q < MAX_WAIT, so no overflow
        starve_d = (grant_dm && if_req_i) ? starve_q + 1'b1 : '0;
        if (grant_dm) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
        end else if (if_req_i) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_valid_q  <= dm_valid_d;
    end
  end
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_valid_o  = dm_valid_q;
  assign stall_if_o  = if_req_i && !if_valid_q;
  assign stall_dm_o  = dm_req_i && !dm_valid_q;
endmodule

// File: tb/tb_moka_rv32_mem_arbiter.sv
// tb_moka_rv32_mem_arbiter: directed bench with a transaction-level reference model checked every cycle.
module tb_moka_rv32_mem_arbiter;
  localparam int DW = 32, MW = 4, TO = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [DW-1:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, rdata_val = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_valid, dm_valid, mem_req, mem_we, mem_ack, stall_if, stall_dm, bus_err;
  logic resp_ack = 0, stray_ack = 0, no_ack = 0;
  int lat = 1, rcnt = 0;
  int n_tests = 0, n_fail = 0;
  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = rdata_val;

  moka_rv32_mem_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_valid_o(dm_valid),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stall_if_o(stall_if), .stall_dm_o(stall_dm), .bus_err_o(bus_err)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // memory: ack after lat cycles of mem_req being high
  always @(negedge clk) begin
    if (mem_req && !resp_ack) begin
      rcnt     <= rcnt + 1;
      resp_ack <= !no_ack && (rcnt + 1 == lat);
    end else begin
      rcnt     <= 0;
      resp_ack <= 1'b0;
    end
  end

  // reference model: phase 0 = idle, 1 = waiting on memory, 2 = response cycle
  int m_ph, m_starve, m_wait;
  bit m_port;
  logic m_req, m_we, m_iv, m_dv, m_err;
  logic [DW-1:0] m_addr, m_wdata, m_ird, m_drd;
  bit glog[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_starve <= 0; m_wait <= 0; m_port <= 0;
      m_req <= 0; m_we <= 0; m_iv <= 0; m_dv <= 0; m_err <= 0;
      m_addr <= '0; m_wdata <= '0; m_ird <= '0; m_drd <= '0;
    end else if (m_ph == 0) begin
      if (dm_req && (!if_req || m_starve < MW)) begin
        m_ph <= 1; m_port <= 1; m_req <= 1; m_we <= dm_we;
        m_addr <= dm_addr; m_wdata <= dm_wdata; m_wait <= 0;
        glog.push_back(1'b1);
      end else if (if_req) begin
        m_ph <= 1; m_port <= 0; m_req <= 1; m_we <= 0;
        m_addr <= if_addr; m_wdata <= '0; m_wait <= 0;
        glog.push_back(1'b0);
      end
      m_starve <= !if_req ? 0 : (dm_req && m_starve < MW) ? m_starve + 1 : 0;
    end else if (m_ph == 1) begin
      if (mem_ack) begin
        m_req <= 0; m_ph <= 2;
        if (m_port) begin m_drd <= mem_rdata; m_dv <= 1; end
        else begin m_ird <= mem_rdata; m_iv <= 1; end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (m_wait + 1 == TO) begin
        m_req <= 0; m_ph <= 2; m_err <= 1;
        if (m_port) begin m_drd <= 32'hDEAD_BEEF; m_dv <= 1; end
        else begin m_ird <= 32'hDEAD_BEEF; m_iv <= 1; end
      end
`endif
      else m_wait <= m_wait + 1;
    end else begin
      m_ph <= 0; m_iv <= 0; m_dv <= 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("mem_req", 32'(mem_req), 32'(m_req));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_valid", 32'(if_valid), 32'(m_iv));
      chk("dm_valid", 32'(dm_valid), 32'(m_dv));
      chk("if_rdata", if_rdata, m_ird);
      chk("dm_rdata", dm_rdata, m_drd);
      chk("stall_if", 32'(stall_if), 32'(if_req && !m_iv));
      chk("stall_dm", 32'(stall_dm), 32'(dm_req && !m_dv));
      chk("bus_err", 32'(bus_err), 32'(m_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, nf, nv, n;
    logic [9:0] pat;
    repeat (2) @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst if_valid", 32'(if_valid), 0);
    chk("rst dm_valid", 32'(dm_valid), 0);
    chk("rst bus_err", 32'(bus_err), 0);
    rst_n = 1;
    @(negedge clk);
    // fetch only, zero-wait memory
    if_req = 1; if_addr = 32'h10; rdata_val = 32'h0051_0113;
    #1 chk("t1 stall_if c0", 32'(stall_if), 1);
    @(negedge clk);
    chk("t1 mem_req c1", 32'(mem_req), 1);
    chk("t1 mem_addr c1", mem_addr, 32'h10);
    chk("t1 stall_if c1", 32'(stall_if), 1);
    @(negedge clk);
    chk("t1 if_valid c2", 32'(if_valid), 1);
    chk("t1 if_rdata c2", if_rdata, 32'h0051_0113);
    chk("t1 stall_if c2", 32'(stall_if), 0);
    if_req = 0;
    @(negedge clk);
    chk("t1 if_valid c3", 32'(if_valid), 0);
    chk("t1 if_rdata hold", if_rdata, 32'h0051_0113);
    // simultaneous requests: data first
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 1; dm_addr = 32'h100;
    dm_wdata = 32'hCAFE_F00D; rdata_val = 32'h1111_1111;
    @(negedge clk);
    chk("t2 mem_we", 32'(mem_we), 1);
    chk("t2 mem_addr", mem_addr, 32'h100);
    chk("t2 mem_wdata", mem_wdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t2 dm_valid", 32'(dm_valid), 1);
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    chk("t2 idle gap", 32'(mem_req), 0);
    @(negedge clk);
    chk("t2 fetch mem_req", 32'(mem_req), 1);
    chk("t2 fetch mem_addr", mem_addr, 32'h20);
    chk("t2 fetch mem_we", 32'(mem_we), 0);
    @(negedge clk);
    chk("t2 if_valid", 32'(if_valid), 1);
    if_req = 0;
    @(negedge clk);
    // starvation bound
    g0 = glog.size(); nf = 0;
    if_req = 1; if_addr = 32'h30; dm_req = 1; dm_addr = 32'h200;
    for (int i = 0; i < 100 && nf < 2; i++) begin
      @(negedge clk);
      if (dm_valid) dm_addr = dm_addr + 4;
      if (if_valid) nf++;
    end
    if_req = 0; dm_req = 0;
    chk("t3 fetches done", 32'(nf), 2);
    chk("t3 grant count", 32'(glog.size() - g0), 10);
    pat = 10'b0111101111;
    for (int i = 0; i < 10 && g0 + i < glog.size(); i++)
      chk("t3 grant order", 32'(glog[g0 + i]), 32'(pat[i]));
    @(negedge clk);
    // slow memory, address change mid-wait
    lat = 5; nv = 0;
    if_req = 1; if_addr = 32'h40; rdata_val = 32'h2222_2222;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) chk("t4 mem_addr c1", mem_addr, 32'h40);
      if (i == 3) if_addr = 32'h44;
      if (i == 4) chk("t4 mem_addr c4", mem_addr, 32'h40);
      chk("t4 if_valid", 32'(if_valid), 32'(i == 6));
      if (if_valid) begin nv++; if_req = 0; end
    end
    chk("t4 pulses", 32'(nv), 1);
    stray_ack = 1;
    @(negedge clk);
    stray_ack = 0;
    @(negedge clk);
    chk("t4 stray ack", 32'(mem_req | if_valid | dm_valid), 0);
    // reset in the middle of a data access
    lat = 10;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    repeat (3) @(negedge clk);
    chk("t5 busy", 32'(mem_req), 1);
    rst_n = 0; dm_req = 0;
    #1;
    chk("t5 rst mem_req", 32'(mem_req), 0);
    chk("t5 rst mem_addr", mem_addr, 0);
    chk("t5 rst if_rdata", if_rdata, 0);
    chk("t5 rst stall_dm", 32'(stall_dm), 0);
    @(negedge clk);
    rst_n = 1; nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (dm_valid) nv++;
    end
    chk("t5 no dm_valid", 32'(nv), 0);
    lat = 1; if_req = 1; if_addr = 32'h50; rdata_val = 32'h3333_3333;
    for (int i = 0; i < 10 && !if_valid; i++) @(negedge clk);
    chk("t5 fetch valid", 32'(if_valid), 1);
    chk("t5 fetch rdata", if_rdata, 32'h3333_3333);
    if_req = 0;
    @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
    no_ack = 1; n = 0;
    dm_req = 1; dm_addr = 32'h400;
    for (int i = 0; i < 100 && !dm_valid; i++) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    chk("t6 busy cycles", 32'(n), TO);
    chk("t6 dm_valid", 32'(dm_valid), 1);
    chk("t6 dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t6 bus_err", 32'(bus_err), 1);
    dm_req = 0; no_ack = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h60; rdata_val = 32'h4444_4444;
    for (int i = 0; i < 10 && !if_valid; i++) @(negedge clk);
    chk("t6 fetch valid", 32'(if_valid), 1);
    chk("t6 bus_err sticky", 32'(bus_err), 1);
    if_req = 0;
`else
    n = 0;
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
